demux16_rr_collector: RTL and testbench

16-channel round-robin collector: the upstream counterpart to the team's 1x16 demux. It captures one-bit events from 16 independent sources, stores them as pending, and serialises them onto a single output with a 4-bit channel index and a valid/ready handshake. The index is MSB-first, so it can drive the demux select lines (s0 = out_sel[3] … s3 = out_sel[0]) directly for a round-trip path.

---
 rtl/demux16_rr_collector.sv | 98 +++++++++
 tb/tb_demux16_rr_collector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux16_rr_collector.sv
// 16-channel round-robin event collector. Latches one-bit events per channel and
// serialises them onto a single valid/ready output tagged with an MSB-first index.
module demux16_rr_collector (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_data,
  output logic [3:0]  out_sel,
  output logic [15:0] overflow,
  input  logic        clr_ovf
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  state;
  logic [15:0] pending;
  logic [15:0] data_q;
  logic [3:0]  ptr;

  logic        handshake;
  logic        load_en;
  logic [3:0]  scan_base;
  logic        grant_found;
  logic [3:0]  grant_idx;
  logic [3:0]  cand;
  logic [15:0] grant_onehot;

  assign handshake = (state == HOLD) && out_ready;
  assign load_en   = (state == IDLE) || handshake;

  // A back-to-back load scans from the word being handed off, not the stale pointer.
  assign scan_base = (state == HOLD) ? out_sel + 4'd1 : ptr;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 4'd0;
    cand        = 4'd0;
    for (int k = 0; k < 16; k++) begin
      cand = scan_base + 4'(k);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_onehot = (load_en && grant_found) ? (16'd1 << grant_idx) : 16'd0;
  assign out_valid    = (state == HOLD);

  // A new request always wins over the grant clearing its pending bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 16'd0;
      data_q   <= 16'd0;
      overflow <= 16'd0;
    end else begin
      pending  <= (pending & ~grant_onehot) | req;
      data_q   <= (data_q & ~req) | (din & req);
      overflow <= (req & pending & ~grant_onehot) | (overflow & ~{16{clr_ovf}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 4'd0;
      out_data <= 1'b0;
      out_sel  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            out_data <= data_q[grant_idx];
            out_sel  <= grant_idx;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            ptr <= out_sel + 4'd1;
            if (grant_found) begin
              out_data <= data_q[grant_idx];
              out_sel  <= grant_idx;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux16_rr_collector.sv
// Self-checking bench for demux16_rr_collector: behavioural event model compared
// every cycle, plus directed cases with hand-computed expectations.
module tb_demux16_rr_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = 16'd0;
  logic [15:0] din = 16'd0;
  logic        out_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        out_valid;
  logic        out_data;
  logic [3:0]  out_sel;
  logic [15:0] overflow;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  bit record_en = 1'b0;
  int hs_q[$];

  // Behavioural model: per-channel pending/data arrays, a pointer and one output word.
  bit m_pend[16];
  bit m_dat[16];
  bit m_ovf[16];
  int m_ptr = 0;
  int m_sel = 0;
  bit m_valid = 1'b0;
  bit m_data = 1'b0;
  int mbase, mg, mc;
  bit mfound, mhs, mgr;

  demux16_rr_collector dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ovf_vec();
    logic [15:0] v;
    v = 16'd0;
    for (int i = 0; i < 16; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_pend[i] = 1'b0;
        m_dat[i]  = 1'b0;
        m_ovf[i]  = 1'b0;
      end
      m_ptr = 0; m_sel = 0; m_valid = 1'b0; m_data = 1'b0;
    end else begin
      mhs   = m_valid && out_ready;
      mbase = m_valid ? (m_sel + 1) % 16 : m_ptr;
      mfound = 1'b0;
      mg = 0;
      for (int k = 0; k < 16; k++) begin
        mc = (mbase + k) % 16;
        if (!mfound && m_pend[mc]) begin
          mfound = 1'b1;
          mg = mc;
        end
      end
      mgr = mfound && (!m_valid || mhs);
      for (int i = 0; i < 16; i++) begin
        if (req[i] && m_pend[i] && !(mgr && mg == i)) m_ovf[i] = 1'b1;
        else if (clr_ovf) m_ovf[i] = 1'b0;
      end
      if (mhs) begin
        m_ptr = (m_sel + 1) % 16;
        m_valid = 1'b0;
      end
      if (mgr) begin
        m_valid = 1'b1;
        m_sel = mg;
        m_data = m_dat[mg];
        m_pend[mg] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
        if (req[i]) begin
          m_pend[i] = 1'b1;
          m_dat[i]  = din[i];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic [15:0] d, input logic rdy, input logic clr);
    @(negedge clk);
    req = r;
    din = d;
    out_ready = rdy;
    clr_ovf = clr;
  endtask

  always @(negedge clk) begin
    if (rst_n && check_en) begin
      checkOutput("model_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        checkOutput("model_sel", 32'(out_sel), 32'(m_sel));
        checkOutput("model_data", 32'(out_data), 32'(m_data));
      end
      checkOutput("model_overflow", 32'(overflow), 32'(ovf_vec()));
    end
  end

  always @(posedge clk) begin
    if (rst_n && record_en && out_valid && out_ready) hs_q.push_back(int'(out_sel));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int exp_sel[4];
    int exp_dat[4];
    int cnt[16];
    logic [15:0] once_mask;

    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sel", 32'(out_sel), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Single event latency on channel 10
    applyStimulus(16'h0400, 16'h0400, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("lat_not_yet", 32'(out_valid), 32'd0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("lat_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_sel", 32'(out_sel), 32'd10);
    checkOutput("lat_data", 32'(out_data), 32'd1);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("lat_drop", 32'(out_valid), 32'd0);
    checkOutput("lat_ptr", 32'(m_ptr), 32'd11);

    // Move the pointer to 14 with one event on channel 13, then check wrap order
    applyStimulus(16'h2000, 16'h0000, 1'b1, 1'b0);
    repeat (3) applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("wrap_ptr", 32'(m_ptr), 32'd14);
    exp_sel = '{14, 15, 0, 1};
    exp_dat = '{1, 0, 0, 1};
    applyStimulus(16'hC003, 16'h4002, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("wrap_capture", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
      checkOutput("wrap_valid", 32'(out_valid), 32'd1);
      checkOutput("wrap_sel", 32'(out_sel), 32'(exp_sel[i]));
      checkOutput("wrap_data", 32'(out_data), 32'(exp_dat[i]));
    end
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("wrap_end", 32'(out_valid), 32'd0);

    // Back-pressure with channels 3 and 7 pending, pointer at 2
    applyStimulus(16'h0088, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_sel", 32'(out_sel), 32'd3);
    end
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("bp_hold_last", 32'(out_sel), 32'd3);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("bp_next_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_next_sel", 32'(out_sel), 32'd7);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    checkOutput("bp_done", 32'(out_valid), 32'd0);

    // Overflow on channel 2 while channel 9 occupies the output; set beats clear
    applyStimulus(16'h0204, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0004, 16'h0004, 1'b0, 1'b1);
    checkOutput("ovf_hold_sel", 32'(out_sel), 32'd9);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("ovf_set", 32'(overflow), 32'h0004);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("ovf_out_sel", 32'(out_sel), 32'd2);
    checkOutput("ovf_out_data", 32'(out_data), 32'd1);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1);
    checkOutput("ovf_idle", 32'(out_valid), 32'd0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("ovf_cleared", 32'(overflow), 32'h0000);

    // Request on the channel being granted: delivered twice, no overflow
    applyStimulus(16'h0020, 16'h0020, 1'b1, 1'b0);
    applyStimulus(16'h0020, 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("sw_first_sel", 32'(out_sel), 32'd5);
    checkOutput("sw_first_data", 32'(out_data), 32'd1);
    checkOutput("sw_no_ovf", 32'(overflow), 32'h0000);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("sw_second_valid", 32'(out_valid), 32'd1);
    checkOutput("sw_second_sel", 32'(out_sel), 32'd5);
    checkOutput("sw_second_data", 32'(out_data), 32'd0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    checkOutput("sw_idle", 32'(out_valid), 32'd0);
    checkOutput("sw_ovf_still0", 32'(overflow), 32'h0000);

    // Full-load fairness with random back-pressure
    hs_q.delete();
    record_en = 1'b1;
    for (int i = 0; i < 64; i++)
      applyStimulus(16'hFFFF, 16'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 24; i++)
      applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    record_en = 1'b0;
    checkOutput("fair_count_ge16", 32'(hs_q.size() >= 16), 32'd1);
    for (int s = 0; s + 16 <= hs_q.size(); s++) begin
      for (int c = 0; c < 16; c++) cnt[c] = 0;
      for (int j = 0; j < 16; j++) cnt[hs_q[s + j]]++;
      once_mask = 16'd0;
      for (int c = 0; c < 16; c++) once_mask[c] = (cnt[c] == 1);
      checkOutput("fair_window", 32'(once_mask), 32'h0000FFFF);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      applyStimulus(16'($urandom) & 16'($urandom), 16'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0));

    // Asynchronous reset in the middle of a held word on channel 5
    repeat (24) applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h0020, 16'h0020, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0100, 16'h0000, 1'b0, 1'b0);
    checkOutput("rst_pre_sel", 32'(out_sel), 32'd5);
    applyStimulus(16'h0100, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    checkOutput("rst_pre_ovf", 32'(overflow), 32'h0100);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_async_sel", 32'(out_sel), 32'd0);
    checkOutput("rst_async_data", 32'(out_data), 32'd0);
    checkOutput("rst_async_ovf", 32'(overflow), 32'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
      checkOutput("rst_quiet", 32'(out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
